// File: rtl/branch_predictor_if.sv
// Fetch-lookup, execute-update and statistics signals of the branch predictor.
// The master drives fetch/update/flush; the slave (predictor) drives predictions and stats.
interface branch_predictor_if #(
    parameter int XLEN = 32
);
    logic            fetch_valid_i;
    logic [XLEN-1:0] fetch_pc_i;
    logic            pred_hit_o;
    logic            pred_taken_o;
    logic [XLEN-1:0] pred_target_o;
    logic            update_valid_i;
    logic [XLEN-1:0] update_pc_i;
    logic            update_taken_i;
    logic [XLEN-1:0] update_target_i;
    logic            update_pred_taken_i;
    logic [XLEN-1:0] update_pred_target_i;
    logic            flush_i;
    logic            mispredict_o;
    logic [31:0]     branch_cnt_o;
    logic [31:0]     mispred_cnt_o;

    modport master (
        output fetch_valid_i, fetch_pc_i,
        output update_valid_i, update_pc_i, update_taken_i, update_target_i,
        output update_pred_taken_i, update_pred_target_i, flush_i,
        input  pred_hit_o, pred_taken_o, pred_target_o,
        input  mispredict_o, branch_cnt_o, mispred_cnt_o
    );

    modport slave (
        input  fetch_valid_i, fetch_pc_i,
        input  update_valid_i, update_pc_i, update_taken_i, update_target_i,
        input  update_pred_taken_i, update_pred_target_i, flush_i,
        output pred_hit_o, pred_taken_o, pred_target_o,
        output mispredict_o, branch_cnt_o, mispred_cnt_o
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit direction counters, zero-latency lookup,
// execute-side update, whole-table flush and saturating branch/mispredict statistics.
module branch_predictor #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    branch_predictor_if.slave bp
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [XLEN-1:0]  target_q [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];

    logic             mispredict_q;
    logic [31:0]      branch_cnt_q;
    logic [31:0]      mispred_cnt_q;

    logic [IDX_W-1:0] f_idx;
    logic [IDX_W-1:0] u_idx;
    logic [TAG_W-1:0] f_tag;
    logic [TAG_W-1:0] u_tag;
    logic             f_hit;
    logic             f_taken;
    logic             u_hit;
    logic             mispredict_d;
    logic             unused_pc_bits;

    assign f_idx = bp.fetch_pc_i[IDX_W+1:2];
    assign f_tag = bp.fetch_pc_i[XLEN-1:IDX_W+2];
    assign u_idx = bp.update_pc_i[IDX_W+1:2];
    assign u_tag = bp.update_pc_i[XLEN-1:IDX_W+2];

    // Lookup reads the registered table, so a same-cycle update is seen only next cycle.
    assign f_hit   = bp.fetch_valid_i & valid_q[f_idx] & (tag_q[f_idx] == f_tag);
    assign f_taken = f_hit & ctr_q[f_idx][1];
    assign u_hit   = valid_q[u_idx] & (tag_q[u_idx] == u_tag);

    assign bp.pred_hit_o    = f_hit;
    assign bp.pred_taken_o  = f_taken;
    assign bp.pred_target_o = f_taken ? target_q[f_idx] : bp.fetch_pc_i + XLEN'(4);

    assign mispredict_d = bp.update_valid_i &
                          ((bp.update_taken_i != bp.update_pred_taken_i) |
                           (bp.update_taken_i & (bp.update_pred_target_i != bp.update_target_i)));

    assign unused_pc_bits = ^bp.update_pc_i[1:0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (bp.flush_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else if (bp.update_valid_i) begin
            if (u_hit) begin
                if (bp.update_taken_i) begin
                    if (ctr_q[u_idx] != 2'b11) ctr_q[u_idx] <= ctr_q[u_idx] + 2'd1;
                    target_q[u_idx] <= bp.update_target_i;
                end else if (ctr_q[u_idx] != 2'b00) begin
                    ctr_q[u_idx] <= ctr_q[u_idx] - 2'd1;
                end
            end else if (bp.update_taken_i) begin
                // Taken miss allocates (or evicts an alias) with a weakly-taken counter.
                valid_q[u_idx]  <= 1'b1;
                tag_q[u_idx]    <= u_tag;
                target_q[u_idx] <= bp.update_target_i;
                ctr_q[u_idx]    <= 2'b10;
            end
        end
    end

    // Statistics keep counting through a flush.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mispredict_q  <= 1'b0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            mispredict_q <= mispredict_d;
            if (bp.update_valid_i && branch_cnt_q != 32'hFFFF_FFFF)
                branch_cnt_q <= branch_cnt_q + 32'd1;
            if (mispredict_d && mispred_cnt_q != 32'hFFFF_FFFF)
                mispred_cnt_q <= mispred_cnt_q + 32'd1;
        end
    end

    assign bp.mispredict_o  = mispredict_q;
    assign bp.branch_cnt_o  = branch_cnt_q;
    assign bp.mispred_cnt_o = mispred_cnt_q;
endmodule
